// File: rtl/apb_requester.sv
// APB requester: one valid/ready request becomes one SETUP+ACCESS transfer, and the result
// comes back on a valid/ready response port. An ACCESS timeout aborts a hung completer.
module apb_requester #(
   parameter int TIMEOUT = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_write,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   input  logic [2:0]  req_prot,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] out_paddr,
   output logic [2:0]  out_pprot,
   output logic        out_pwrite,
   output logic [31:0] out_pwdata,
   output logic [3:0]  out_pstrb,
   output logic        out_psel,
   output logic        out_penable,
   input  logic        out_pready,
   input  logic [31:0] out_prdata,
   input  logic        out_pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam logic [15:0] CNT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt;
   logic        accept;
   logic        timeout_hit;

   // req_ready is gated by reset so nothing is accepted while reset is held
   assign req_ready   = (state == IDLE) && !reset;
   assign accept      = req_valid && req_ready;
   assign timeout_hit = (TIMEOUT != 0) && !out_pready && (cnt == CNT_LAST);
   assign rsp_valid   = (state == RESP);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (out_pready || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_paddr   <= '0;
         out_pprot   <= '0;
         out_pwrite  <= 1'b0;
         out_pwdata  <= '0;
         out_pstrb   <= '0;
         out_psel    <= 1'b0;
         out_penable <= 1'b0;
         cnt         <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               out_paddr  <= req_addr;
               out_pprot  <= req_prot;
               out_pwrite <= req_write;
               out_pwdata <= req_write ? req_wdata : 32'd0;
               out_pstrb  <= req_write ? req_wstrb : 4'd0;
               out_psel   <= 1'b1;
            end
            SETUP: begin
               out_penable <= 1'b1;
               cnt         <= '0;
            end
            ACCESS: begin
               if (out_pready || timeout_hit) begin
                  // completion beats the timeout when both land on the same cycle
                  rsp_rdata   <= (out_pready && !out_pwrite) ? out_prdata : 32'd0;
                  rsp_err     <= out_pready ? out_pslverr : 1'b1;
                  rsp_timeout <= !out_pready;
                  out_paddr   <= '0;
                  out_pprot   <= '0;
                  out_pwrite  <= 1'b0;
                  out_pwdata  <= '0;
                  out_pstrb   <= '0;
                  out_psel    <= 1'b0;
                  out_penable <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_rdata   <= '0;
               rsp_err     <= 1'b0;
               rsp_timeout <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: stimulus pushes expected responses into a queue, a
// negedge monitor pops and compares them on every response handshake.
module tb_apb_requester;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic [2:0]  req_prot;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [31:0] out_paddr;
   logic [2:0]  out_pprot;
   logic        out_pwrite;
   logic [31:0] out_pwdata;
   logic [3:0]  out_pstrb;
   logic        out_psel, out_penable;
   logic        out_pready;
   logic [31:0] out_prdata;
   logic        out_pslverr;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   apb_requester #(.TIMEOUT(8)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .out_paddr(out_paddr), .out_pprot(out_pprot), .out_pwrite(out_pwrite),
      .out_pwdata(out_pwdata), .out_pstrb(out_pstrb), .out_psel(out_psel),
      .out_penable(out_penable), .out_pready(out_pready), .out_prdata(out_prdata),
      .out_pslverr(out_pslverr)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Response scoreboard
   always @(negedge clock) begin
      if (!reset && rsp_valid && rsp_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b to=%0b, expected no response",
                     rsp_rdata, rsp_err, rsp_timeout);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_err !== e.err || rsp_timeout !== e.tmo) begin
               fails++;
               $display("FAIL %s_rsp: got rdata=0x%0h err=%0b to=%0b, expected rdata=0x%0h err=%0b to=%0b",
                        e.tag, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
            end
         end
      end
   end

   // One transfer. Entered at posedge+1; the completer inserts `waits` wait states.
   task automatic run(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] wstrb, input logic [2:0] prot,
                      input int waits, input logic [31:0] prdata, input logic slverr,
                      input int exp_acc, input int exp_lat, input logic [31:0] exp_rdata,
                      input logic exp_err, input logic exp_to, input int hold, input int exp_stall);
      int stall, acc, lat;
      logic stable;
      logic [31:0] exp_wd;
      logic [3:0]  exp_st;
      logic [34:0] snap;
      exp_t e;
      e.tag = tag; e.rdata = exp_rdata; e.err = exp_err; e.tmo = exp_to;
      exp_q.push_back(e);
      exp_wd = wr ? wdata : 32'd0;
      exp_st = wr ? wstrb : 4'd0;
      req_addr = addr; req_write = wr; req_wdata = wdata; req_wstrb = wstrb; req_prot = prot;
      req_valid = 1'b1;
      stall = 0;
      forever begin
         @(negedge clock);
         if (req_ready) break;
         stall++;
         if (stall > 50) break;
      end
      check({tag, "_stall"}, 64'(stall), 64'(exp_stall));
      @(posedge clock);
      #1 req_valid = 1'b0;
      acc = 0; lat = 0; stable = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clock);
         if (c == 1) begin
            check({tag, "_setup_sel"}, {62'd0, out_psel, out_penable}, 64'h2);
            check({tag, "_setup_addr"}, 64'(out_paddr), 64'(addr));
            check({tag, "_setup_wdata"}, 64'(out_pwdata), 64'(exp_wd));
            check({tag, "_setup_ctl"}, 64'({out_pwrite, out_pprot, out_pstrb}),
                  64'({wr, prot, exp_st}));
         end
         if (rsp_valid) begin
            lat = c;
            out_pready = 1'b0;
            break;
         end
         if (out_penable) begin
            acc++;
            if (!out_psel || out_paddr !== addr || out_pwdata !== exp_wd ||
                out_pwrite !== wr || out_pprot !== prot || out_pstrb !== exp_st)
               stable = 1'b0;
            out_pready  = (acc > waits);
            // garbage on non-ready cycles catches data latched too early
            out_prdata  = out_pready ? prdata : 32'hBAD0_BAD0;
            out_pslverr = out_pready ? slverr : 1'b1;
         end
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_penable_cycles"}, 64'(acc), 64'(exp_acc));
      check({tag, "_fields_stable"}, {63'd0, stable}, 64'd1);
      check({tag, "_apb_idle"}, {out_psel, out_penable, out_paddr}, 64'd0);
      if (hold > 0) begin
         snap = {rsp_valid, req_ready, rsp_rdata, rsp_err};
         for (int i = 0; i < hold; i++) begin
            if (i > 0) @(negedge clock);
            check({tag, "_hold"}, {28'd0, rsp_timeout, rsp_valid, req_ready, rsp_rdata, rsp_err},
                  {28'd0, exp_to, snap});
            check({tag, "_hold_ready"}, {62'd0, rsp_valid, req_ready}, 64'h2);
         end
      end else begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_wstrb = '0;
      req_prot = '0; rsp_ready = 1'b1; out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
      repeat (2) @(negedge clock);
      check("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_timeout, out_psel, out_penable,
                              out_pwrite, out_pstrb, out_pprot}, 64'd0);
      check("reset_data", {out_paddr, rsp_rdata | out_pwdata}, 64'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("idle_req_ready", {63'd0, req_ready}, 64'd1);
      @(posedge clock);
      #1;

      // zero-wait write
      run("t1_write", 32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd2, 0, 32'hFFFF_FFFF, 1'b0,
          1, 3, 32'd0, 1'b0, 1'b0, 0, 0);
      // read with 3 wait states, strobes/wdata forced to 0
      run("t2_read", 32'h1000_0008, 1'b0, 32'h5555_5555, 4'hF, 3'd0, 3, 32'h1234_5678, 1'b0,
          4, 6, 32'h1234_5678, 1'b0, 1'b0, 0, 0);
      // completer error
      run("t3_slverr", 32'h2000_0000, 1'b0, 32'd0, 4'h0, 3'd1, 1, 32'hCAFE_F00D, 1'b1,
          2, 4, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 0);
      // timeout abort, then pready on the final allowed cycle
      run("t4_timeout", 32'h3000_0010, 1'b0, 32'd0, 4'h0, 3'd0, 1000, 32'h7777_7777, 1'b0,
          8, 10, 32'd0, 1'b1, 1'b1, 0, 0);
      run("t4_last_cycle", 32'h3000_0014, 1'b0, 32'd0, 4'h0, 3'd0, 7, 32'hA5A5_0008, 1'b0,
          8, 10, 32'hA5A5_0008, 1'b0, 1'b0, 0, 0);
      run("t4_write_timeout", 32'h3000_0018, 1'b1, 32'h0123_4567, 4'h3, 3'd4, 1000, 32'h0, 1'b0,
          8, 10, 32'd0, 1'b1, 1'b1, 0, 0);

      // backpressured response, then back-to-back request
      rsp_ready = 1'b0;
      run("t5_hold", 32'h4000_0000, 1'b1, 32'h0BAD_F00D, 4'h5, 3'd3, 0, 32'd0, 1'b1,
          1, 3, 32'd0, 1'b1, 1'b0, 5, 0);
      @(posedge clock);
      #1 rsp_ready = 1'b1;
      run("t5_next", 32'h4000_0004, 1'b0, 32'd0, 4'h0, 3'd0, 0, 32'h0000_BEEF, 1'b0,
          1, 3, 32'h0000_BEEF, 1'b0, 1'b0, 0, 1);

      // reset pulse mid-ACCESS of a write
      req_addr = 32'h5000_0000; req_write = 1'b1; req_wdata = 32'hFEED_FACE; req_wstrb = 4'hF;
      req_prot = 3'd0; req_valid = 1'b1; out_pready = 1'b0;
      @(negedge clock);
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clock);
      check("t6_in_access", {62'd0, out_psel, out_penable}, 64'h3);
      #2 reset = 1'b1;
      #1;
      check("t6_reset_apb", {req_ready, rsp_valid, out_psel, out_penable, out_paddr}, 64'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         repeat (5) begin
            @(negedge clock);
            if (rsp_valid || out_psel) seen = 1'b1;
         end
         check("t6_no_response", {63'd0, seen}, 64'd0);
      end
      @(posedge clock);
      #1;
      run("t6_after", 32'h5000_0008, 1'b0, 32'd0, 4'h0, 3'd0, 0, 32'h600D_0006, 1'b0,
          1, 3, 32'h600D_0006, 1'b0, 1'b0, 0, 0);

      repeat (3) @(negedge clock);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
